// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the front-end blocks.
//   XLEN              : datapath / address width
//   RESET_PC_DEFAULT  : instruction index fetched first after reset
//   fetch_state_e     : fetch request tracker states
//                       FETCH_RUN  - nothing outstanding
//                       FETCH_WAIT - one request outstanding, response kept
//                       FETCH_DROP - one request outstanding, response discarded
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_RUN  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {instruction, index} pairs.
// The head entry is read straight out of the storage registers, so a word
// written on one edge is visible on the output only after that edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full without a pop)
//   push_data   : entry to write
//   pop         : remove the head entry (ignored when empty)
//   flush       : discard all entries; wins over push and pop
//   pop_data    : head entry, zero when empty
//   count       : number of stored entries
//   full, empty : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2 * XLEN,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   assign empty = (count_reg == '0);
   assign full  = (count_reg == FULL_COUNT);
   assign count = count_reg;

   assign do_pop  = pop && !empty && !flush;
   // A pop on the same edge frees the slot, so a full FIFO may still accept.
   assign do_push = push && !flush && (!full || do_pop);

   assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

   // Storage carries no reset; validity is tracked by count_reg alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: issues one word request at a time to the
// instruction memory, buffers returned words in fetch_fifo and hands them to
// decode with a valid/ready handshake. A redirect from execute reloads the
// pc, flushes the buffer and marks any in-flight response as stale.
//   clk, rst_n         : clock, asynchronous active-low reset
//   imem_req/imem_addr : single-cycle request pulse and word address
//   imem_rvalid/rdata  : in-order response, at least one cycle after request
//   global_disable     : redirect strobe (taken branch)
//   delta_instruction  : signed offset added to branch_pc on redirect
//   branch_pc          : index of the branching instruction
//   instr/instr_pc     : oldest buffered word and its index
//   instr_valid        : buffer not empty
//   instr_ready        : decode accepts the current word
// ---------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            global_disable,
   input  logic [XLEN-1:0] delta_instruction,
   input  logic [XLEN-1:0] branch_pc,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e    state_reg;
   fetch_state_e    state_next;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] req_pc_reg;

   logic              issue;
   logic              push;
   logic              pop;
   logic [2*XLEN-1:0] fifo_head;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              unused_fifo_full;

   // rst_n gates the request so that nothing is presented while held in
   // reset, yet the first request is already up for the first active edge.
   assign issue = rst_n && (state_reg == FETCH_RUN) && !global_disable &&
                  (fifo_count < CW'(DEPTH));

   assign imem_req  = issue;
   assign imem_addr = issue ? pc_reg : '0;

   // Only a response to a request that survived every redirect is kept.
   assign push = (state_reg == FETCH_WAIT) && imem_rvalid && !global_disable;
   assign pop  = instr_valid && instr_ready;

   // Occupancy is gated through fifo_count; the full flag is redundant here.
   assign unused_fifo_full = fifo_full;

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         FETCH_RUN: begin
            if (issue) begin
               state_next = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid) begin
               state_next = FETCH_RUN;
            end else if (global_disable) begin
               state_next = FETCH_DROP;
            end
         end
         FETCH_DROP: begin
            if (imem_rvalid) begin
               state_next = FETCH_RUN;
            end
         end
         default: state_next = FETCH_RUN;
      endcase
   end

   always_comb begin
      pc_next = pc_reg;
      if (global_disable) begin
         pc_next = branch_pc + delta_instruction;
      end else if (issue) begin
         pc_next = pc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= FETCH_RUN;
         pc_reg     <= RESET_PC;
         req_pc_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         if (issue) begin
            req_pc_reg <= pc_reg;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({imem_rdata, req_pc_reg}),
      .pop       (pop),
      .flush     (global_disable),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign instr_valid = !fifo_empty;
   assign instr       = fifo_head[2*XLEN-1:XLEN];
   assign instr_pc    = fifo_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Randomised and directed bench for fetch_unit. A queue-based reference model
// tracks the pc, whether a request is in flight (and whether it went stale),
// and the instruction buffer contents; a negedge compare process checks every
// DUT output against it each cycle. Directed phases pin the model with
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        global_disable = 1'b0;
   logic [31:0] delta_instruction = 32'h0;
   logic [31:0] branch_pc = 32'h0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic [31:0] w_instr;
   logic [31:0] w_instr_pc;
   logic        w_instr_valid;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .global_disable(global_disable), .delta_instruction(delta_instruction),
      .branch_pc(branch_pc), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .DEPTH(DEPTH)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .global_disable(global_disable), .delta_instruction(delta_instruction),
      .branch_pc(branch_pc), .instr(w_instr), .instr_pc(w_instr_pc),
      .instr_valid(w_instr_valid), .instr_ready(instr_ready)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc = 32'h0;
   bit          m_out = 1'b0;    // a request is in flight
   bit          m_stale = 1'b0;  // its response must be thrown away
   logic [31:0] m_req = 32'h0;   // index of the in-flight request
   logic [63:0] m_q[$];          // buffered {instr, index}, oldest first

   task automatic model_step();
      bit can_issue;
      if (!rst_n) begin
         m_pc = 32'h0;
         m_out = 1'b0;
         m_stale = 1'b0;
         m_q.delete();
      end else begin
         can_issue = !m_out && !global_disable && (m_q.size() < DEPTH);
         if (global_disable) begin
            if (m_out) begin
               if (imem_rvalid) begin
                  m_out = 1'b0;
                  m_stale = 1'b0;
               end else begin
                  m_stale = 1'b1;
               end
            end
            m_q.delete();
            m_pc = branch_pc + delta_instruction;
         end else begin
            if (instr_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_out && imem_rvalid) begin
               if (!m_stale) m_q.push_back({imem_rdata, m_req});
               m_out = 1'b0;
               m_stale = 1'b0;
            end
            if (can_issue) begin
               m_out = 1'b1;
               m_stale = 1'b0;
               m_req = m_pc;
               m_pc = m_pc + 32'd1;
            end
         end
      end
   endtask

   always @(posedge clk) model_step();

   // ---------------- memory + logs ----------------
   bit          pend_v = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_due = 0;
   int          fixed_lat = 1;
   bit          rand_lat = 1'b0;

   logic [31:0] req_log[$];
   logic [31:0] wrap_log[$];
   logic [31:0] acc_pc[$];
   logic [31:0] acc_instr[$];
   int          acc_cyc[$];

   bit exp_req;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req", {31'b0, imem_req}, 32'd0);
         chk("rst_addr", imem_addr, 32'd0);
         chk("rst_valid", {31'b0, instr_valid}, 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_instr_pc", instr_pc, 32'd0);
      end else begin
         exp_req = !m_out && !global_disable && (m_q.size() < DEPTH);
         chk("req", {31'b0, imem_req}, {31'b0, exp_req});
         if (exp_req) chk("addr", imem_addr, m_pc);
         chk("valid", {31'b0, instr_valid}, {31'b0, m_q.size() > 0});
         chk("wrap_valid", {31'b0, w_instr_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) begin
            chk("instr", instr, m_q[0][63:32]);
            chk("instr_pc", instr_pc, m_q[0][31:0]);
         end
         if (imem_req) begin
            pend_v = 1'b1;
            pend_addr = imem_addr;
            pend_due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : fixed_lat);
            req_log.push_back(imem_addr);
         end
         if (w_imem_req) wrap_log.push_back(w_imem_addr);
         if (instr_valid && instr_ready) begin
            acc_pc.push_back(instr_pc);
            acc_instr.push_back(instr);
            acc_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (pend_v && cyc >= pend_due) begin
         imem_rvalid = 1'b1;
         imem_rdata = 32'hE000_0000 + pend_addr;
         pend_v = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata = $urandom;
      end
   endtask

   task automatic clear_logs();
      req_log.delete();
      wrap_log.delete();
      acc_pc.delete();
      acc_instr.delete();
      acc_cyc.delete();
   endtask

   // Asserts reset right now (asynchronously), holds it two edges, releases.
   // With late=1 a leftover response strobe is presented on release.
   task automatic do_reset(input bit late);
      rst_n = 1'b0;
      global_disable = 1'b0;
      imem_rvalid = 1'b0;
      pend_v = 1'b0;
      tick();
      tick();
      clear_logs();
      rst_n = 1'b1;
      if (late) begin
         imem_rvalid = 1'b1;
         imem_rdata = 32'hBAD0_BAD0;
      end
   endtask

   task automatic wait_acc(input string name, input int n, input int budget);
      int k = 0;
      while (acc_pc.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(name, {31'b0, acc_pc.size() >= n}, 32'd1);
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hXXXX_XXXX;
   endfunction

   initial begin
      int k;
      // ---- in-order fetch with 1-cycle memory, wrap-around instance ----
      fixed_lat = 1;
      rand_lat = 1'b0;
      instr_ready = 1'b1;
      do_reset(1'b0);
      wait_acc("a_timeout", 4, 40);
      for (int i = 0; i < 4; i++) begin
         chk("a_pc", qget(acc_pc, i), 32'(i));
         chk("a_instr", qget(acc_instr, i), 32'hE000_0000 + 32'(i));
      end
      if (acc_cyc.size() >= 2) chk("a_rate", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("a_first_addr", qget(req_log, 0), 32'h0000_0000);
      chk("wrap_addr0", qget(wrap_log, 0), 32'hFFFF_FFFF);
      chk("wrap_addr1", qget(wrap_log, 1), 32'h0000_0000);

      // ---- decode stall: buffer fills, requests stop ----
      instr_ready = 1'b0;
      do_reset(1'b0);
      repeat (10) tick();
      @(negedge clk);
      chk("b_req_stop", {31'b0, imem_req}, 32'd0);
      chk("b_valid", {31'b0, instr_valid}, 32'd1);
      chk("b_pc_held", instr_pc, 32'd0);
      chk("b_instr_held", instr, 32'hE000_0000);
      instr_ready = 1'b1;
      wait_acc("b_timeout", 4, 40);
      for (int i = 0; i < 4; i++) chk("b_pc", qget(acc_pc, i), 32'(i));

      // ---- redirect while a request is outstanding ----
      fixed_lat = 2;
      instr_ready = 1'b0;
      do_reset(1'b0);
      k = 0;
      while (!(instr_valid && pend_v) && k < 30) begin
         tick();
         k++;
      end
      chk("c_setup", {31'b0, instr_valid && pend_v}, 32'd1);
      global_disable = 1'b1;
      branch_pc = 32'd5;
      delta_instruction = 32'hFFFF_FFFD;
      tick();
      global_disable = 1'b0;
      clear_logs();
      @(negedge clk);
      chk("c_flushed", {31'b0, instr_valid}, 32'd0);
      instr_ready = 1'b1;
      wait_acc("c_timeout", 1, 30);
      chk("c_next_addr", qget(req_log, 0), 32'd2);
      chk("c_next_pc", qget(acc_pc, 0), 32'd2);
      chk("c_next_instr", qget(acc_instr, 0), 32'hE000_0002);

      // ---- redirect coincident with a response ----
      fixed_lat = 2;
      do_reset(1'b0);
      k = 0;
      while (!imem_rvalid && k < 30) begin
         tick();
         k++;
      end
      chk("d_setup", {31'b0, imem_rvalid}, 32'd1);
      global_disable = 1'b1;
      branch_pc = 32'd10;
      delta_instruction = 32'd7;
      tick();
      global_disable = 1'b0;
      clear_logs();
      wait_acc("d_timeout", 1, 30);
      chk("d_next_addr", qget(req_log, 0), 32'd17);
      chk("d_next_pc", qget(acc_pc, 0), 32'd17);

      // ---- reset during WAIT, late response after release ----
      fixed_lat = 3;
      do_reset(1'b0);
      k = 0;
      while (!pend_v && k < 30) begin
         tick();
         k++;
      end
      chk("e_setup", {31'b0, pend_v}, 32'd1);
      do_reset(1'b1);
      wait_acc("e_timeout", 1, 30);
      chk("e_first_addr", qget(req_log, 0), 32'd0);
      chk("e_first_pc", qget(acc_pc, 0), 32'd0);
      chk("e_first_instr", qget(acc_instr, 0), 32'hE000_0000);

      // ---- randomised traffic ----
      rand_lat = 1'b1;
      do_reset(1'b0);
      for (int i = 0; i < 3000; i++) begin
         tick();
         instr_ready = ($urandom_range(0, 3) != 0);
         global_disable = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0)
            branch_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else
            branch_pc = $urandom;
         delta_instruction = 32'($urandom_range(0, 64)) - 32'd32;
         if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1) == 1);
      end
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
